// File: rtl/debounce_edge_pkg.sv
// rtl/debounce_edge_pkg.sv - shared state encodings and default parameters for debounce_edge
package debounce_edge_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_EDGE_W        = 8;

endpackage

// File: rtl/debounce_edge_stable_counter.sv
// rtl/debounce_edge_stable_counter.sv - qualification counter: clear, load-to-1, increment, terminal count
module stable_counter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CW            = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CW'(1);
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(STABLE_CYCLES - 1));

endmodule

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - glitch filter with registered level, rise/fall pulses and rising-edge counter
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int EDGE_W        = DEF_EDGE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic              q,
  output logic              rise,
  output logic              fall,
  output logic              busy,
  output logic [EDGE_W-1:0] edge_cnt
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
    $error("debounce_edge: STABLE_CYCLES must be in 2..255");
  end

  localparam int CW = $clog2(STABLE_CYCLES);

  state_t        state;
  logic          cnt_clr;
  logic          cnt_load;
  logic          cnt_inc;
  logic          cnt_tc;
  logic [CW-1:0] cnt;

  stable_counter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CW            (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .load1 (cnt_load),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  // Counter follows the FSM decision for this edge; it restarts at 1 on each new candidate.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      STABLE_LO: cnt_load = din;
      CHECK_HI: begin
        if (!din || cnt_tc) cnt_clr = 1'b1;
        else                cnt_inc = 1'b1;
      end
      STABLE_HI: cnt_load = !din;
      CHECK_LO: begin
        if (din || cnt_tc) cnt_clr = 1'b1;
        else               cnt_inc = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= STABLE_LO;
      q        <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      busy     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (din) begin
            state <= CHECK_HI;
            busy  <= 1'b1;
          end
        end
        CHECK_HI: begin
          if (!din) begin
            state <= STABLE_LO;
            busy  <= 1'b0;
          end else if (cnt_tc) begin
            state    <= STABLE_HI;
            q        <= 1'b1;
            rise     <= 1'b1;
            busy     <= 1'b0;
            edge_cnt <= edge_cnt + EDGE_W'(1);
          end
        end
        STABLE_HI: begin
          if (!din) begin
            state <= CHECK_LO;
            busy  <= 1'b1;
          end
        end
        CHECK_LO: begin
          if (din) begin
            state <= STABLE_HI;
            busy  <= 1'b0;
          end else if (cnt_tc) begin
            state <= STABLE_LO;
            q     <= 1'b0;
            fall  <= 1'b1;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - self-checking bench for debounce_edge against a run-length reference model
`timescale 1ps/1ps
module tb_debounce_edge;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0;

  logic       qa, ra, fa, ba;
  logic [7:0] ca;
  logic       qb, rb, fb, bb;
  logic [1:0] cb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debounce_edge #(.STABLE_CYCLES(4), .EDGE_W(8)) dut_a (
    .clk(clk), .reset(reset), .din(din),
    .q(qa), .rise(ra), .fall(fa), .busy(ba), .edge_cnt(ca)
  );

  debounce_edge #(.STABLE_CYCLES(2), .EDGE_W(2)) dut_b (
    .clk(clk), .reset(reset), .din(din),
    .q(qb), .rise(rb), .fall(fb), .busy(bb), .edge_cnt(cb)
  );

  wire [11:0] obs_a = {qa, ra, fa, ba, ca};
  wire [5:0]  obs_b = {qb, rb, fb, bb, cb};

  // Model: count consecutive samples that differ from the accepted level; accept at N.
  int         nst[2]  = '{4, 2};
  int         modv[2] = '{256, 4};
  logic       mq[2], mr[2], mf[2];
  int         run[2], mcnt[2];
  logic [11:0] exp_a;
  logic [5:0]  exp_b;

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      mr[i] = 1'b0;
      mf[i] = 1'b0;
      if (!reset) begin
        mq[i] = 1'b0; run[i] = 0; mcnt[i] = 0;
      end else if (din != mq[i]) begin
        run[i]++;
        if (run[i] == nst[i]) begin
          mq[i]  = din;
          run[i] = 0;
          if (din) begin
            mr[i]   = 1'b1;
            mcnt[i] = (mcnt[i] + 1) % modv[i];
          end else begin
            mf[i] = 1'b1;
          end
        end
      end else begin
        run[i] = 0;
      end
    end
    exp_a = {mq[0], mr[0], mf[0], run[0] != 0, 8'(mcnt[0])};
    exp_b = {mq[1], mr[1], mf[1], run[1] != 0, 2'(mcnt[1])};
  endtask

  task automatic tick(input logic d, input logic r);
    din   = d;
    reset = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0);
      if (obs_a !== 12'h000) begin errors++; $display("FAIL reset_a cyc%0d: got %h exp %h", i, obs_a, 12'h000); end
      checks++;
      if (obs_b !== 6'h00) begin errors++; $display("FAIL reset_b cyc%0d: got %h exp %h", i, obs_b, 6'h00); end
      checks++;
    end
  endtask

  task automatic test_clean_rise();
    int rises = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, 1'b1);
      rises += ra;
      if (obs_a !== exp_a) begin errors++; $display("FAIL rise_a cyc%0d: got %h exp %h", i, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL rise_b cyc%0d: got %h exp %h", i, obs_b, exp_b); end
      checks++;
      if (i == 1 && ba !== 1'b1) begin errors++; $display("FAIL rise_busy_first: got %b exp 1", ba); end
      if (i == 1) checks++;
      if (i == 4 && {qa, ra} !== 2'b11) begin errors++; $display("FAIL rise_at_4th: got q%b r%b exp q1 r1", qa, ra); end
      if (i == 4) checks++;
    end
    if (rises != 1 || ca !== 8'd1) begin errors++; $display("FAIL rise_once: got rises=%0d cnt=%0d exp 1 1", rises, ca); end
    checks++;
  endtask

  task automatic test_clean_fall();
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 1'b1);
      if (obs_a !== exp_a) begin errors++; $display("FAIL fall_a cyc%0d: got %h exp %h", i, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL fall_b cyc%0d: got %h exp %h", i, obs_b, exp_b); end
      checks++;
      if (i == 4 && {qa, fa, ca} !== {1'b0, 1'b1, 8'd1}) begin
        errors++; $display("FAIL fall_at_4th: got q%b f%b c%0d exp q0 f1 c1", qa, fa, ca);
      end
      if (i == 4) checks++;
    end
  endtask

  task automatic test_glitch();
    int rises = 0;
    for (int i = 1; i <= 4; i++) begin
      tick(i < 4, 1'b1);
      rises += ra;
      if (obs_a !== exp_a) begin errors++; $display("FAIL glitch_a cyc%0d: got %h exp %h", i, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL glitch_b cyc%0d: got %h exp %h", i, obs_b, exp_b); end
      checks++;
    end
    if (rises != 0 || qa !== 1'b0 || ba !== 1'b0) begin
      errors++; $display("FAIL glitch_filtered: got rises=%0d q%b b%b exp 0 0 0", rises, qa, ba);
    end
    checks++;
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b1);
      if (obs_a !== exp_a) begin errors++; $display("FAIL reglitch_a cyc%0d: got %h exp %h", i, obs_a, exp_a); end
      checks++;
    end
    if ({qa, ra, ca} !== {1'b1, 1'b1, 8'd2}) begin
      errors++; $display("FAIL glitch_requalify: got q%b r%b c%0d exp q1 r1 c2", qa, ra, ca);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    if ({qa, ra, ba, ca} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL reset_mid: got q%b r%b b%b c%0d exp q0 r0 b0 c0", qa, ra, ba, ca);
    end
    checks++;
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b1);
      if (obs_a !== exp_a) begin errors++; $display("FAIL restart_a cyc%0d: got %h exp %h", i, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL restart_b cyc%0d: got %h exp %h", i, obs_b, exp_b); end
      checks++;
      if (ra !== (i == 4)) begin errors++; $display("FAIL restart_rise cyc%0d: got %b exp %b", i, ra, i == 4); end
      checks++;
    end
  endtask

  task automatic test_wrap();
    logic [1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tick(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
      if (cb !== want[k] || obs_b !== exp_b) begin
        errors++; $display("FAIL wrap_b round%0d: got %0d (%h) exp %0d (%h)", k, cb, obs_b, want[k], exp_b);
      end
      checks++;
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
      if (obs_a !== exp_a) begin errors++; $display("FAIL wrap_a round%0d: got %h exp %h", k, obs_a, exp_a); end
      checks++;
    end
  endtask

  task automatic test_random();
    logic d = 1'b0;
    logic r;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2, 0) == 0) d = ~d;
      r = ($urandom_range(49, 0) != 0);
      tick(d, r);
      if (obs_a !== exp_a) begin errors++; $display("FAIL random_a cyc%0d: got %h exp %h", i, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL random_b cyc%0d: got %h exp %h", i, obs_b, exp_b); end
      checks++;
      if (ra && fa) begin errors++; $display("FAIL random_exclusive cyc%0d: got r%b f%b exp not both", i, ra, fa); end
      checks++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mq[i] = 1'b0; mr[i] = 1'b0; mf[i] = 1'b0; run[i] = 0; mcnt[i] = 0;
    end
    exp_a = '0;
    exp_b = '0;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Downstream consumer of the single-bit D flip-flop stage: takes that flop's registered Q output as `din`.
- Filters glitches by requiring `din` to hold a new level for STABLE_CYCLES consecutive clock edges before the debounced level `q` changes.
- Emits single-cycle rise/fall pulses and keeps a wrapping count of debounced rising edges.
- Feeds button/switch consumers (counters, FSM triggers) in the lab designs.

Parameters:
- STABLE_CYCLES, 4, consecutive sampled cycles of a new level needed to accept it; legal range 2..255.
- EDGE_W, 8, width of the debounced rising-edge counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- din  input  1  raw level from the upstream D flip-flop Q; already clock-domain-aligned.
- q  output  1  debounced level.
- rise  output  1  one-cycle pulse when q goes 0->1.
- fall  output  1  one-cycle pulse when q goes 1->0.
- busy  output  1  high while a candidate level change is being qualified.
- edge_cnt  output  EDGE_W  count of rise pulses; wraps.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a rising edge) overrides everything:
  - state=STABLE_LO, cnt=0.
  - q=0, rise=0, fall=0, busy=0, edge_cnt=0.
- Reset asserted mid-qualification abandons the candidate; no pulse is produced.
- States are STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO. Transitions, evaluated per rising edge with reset==1:
  - STABLE_LO: din==1 -> CHECK_HI, cnt=1, busy=1. Else stay.
  - CHECK_HI:
    - din==0 -> STABLE_LO, cnt=0, busy=0.
    - else if cnt==STABLE_CYCLES-1 -> STABLE_HI, q=1, rise=1, busy=0, cnt=0, edge_cnt+=1.
    - else cnt+=1.
  - STABLE_HI: din==0 -> CHECK_LO, cnt=1, busy=1. Else stay.
  - CHECK_LO:
    - din==1 -> STABLE_HI, cnt=0, busy=0.
    - else if cnt==STABLE_CYCLES-1 -> STABLE_LO, q=0, fall=1, busy=0, cnt=0.
    - else cnt+=1.
- rise and fall default to 0 every cycle and are never high together.
- Latency:
  - din first sampled at its new level on edge k.
  - With din held, q, rise and fall update on edge k+STABLE_CYCLES-1, i.e. after STABLE_CYCLES samples.
- Glitch filtering: any return of din to the current q level during CHECK_* resets qualification. The next change starts again from cnt=1.
- cnt width is the minimum needed to hold STABLE_CYCLES-1; it never exceeds STABLE_CYCLES-1.
- edge_cnt is modulo 2^EDGE_W: 2^EDGE_W-1 plus a rise gives 0. It has no saturation and no overflow flag.
- STABLE_CYCLES<2 is illegal; elaboration must fail via a generate-time check.

Decomposition:
- Shared package/include (debounce_defs):
  - 2-bit state encodings: STABLE_LO=0, CHECK_HI=1, STABLE_HI=2, CHECK_LO=3.
  - Default STABLE_CYCLES and EDGE_W constants.
- One natural sub-module, stable_counter: loadable up-counter with clear, load-to-1, increment and terminal-count (==STABLE_CYCLES-1) output.
- The FSM, pulse registers and edge_cnt stay in debounce_edge.

Test Plan:
- Reset: hold reset=0 for 2 edges with din=1 -> q=0, rise=0, fall=0, busy=0, edge_cnt=0; state stays STABLE_LO while reset=0.
- Clean rise: release reset, din=1 held 6 cycles (10ps period) -> busy=1 from the first edge; q=1 and rise=1 for exactly one cycle on the 4th sampling edge; edge_cnt=1.
- Glitch: from q=0, din=1 for 3 edges then 0 -> q stays 0, no rise, busy returns 0. Then din=1 for 4 edges -> rise, q=1.
- Clean fall: from q=1, din=0 held 4 edges -> fall=1 one cycle, q=0, edge_cnt unchanged.
- Reset mid-check: din=1 for 2 edges, then reset=0 on the 3rd -> no rise, q=0, busy=0, edge_cnt=0. After release, qualification restarts from cnt=1.
- Wrap: EDGE_W=2, drive 5 qualified high/low cycles -> edge_cnt sequence 1,2,3,0,1.
